dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that sits directly downstream of the core's MEM stage, in place of the ideal data RAM.
- Its `miss` output drives the hazard unit's DCacheMiss input, which today is tied to 0.
- On a miss it stalls the pipeline, runs a victim write-back burst and a line-fill burst to main memory, then serves the held request.
- Two free-running counters (accesses, misses) expose hit rate for the branch/cache experiments.

---
 rtl/dcache_pkg.sv | 16 +
 rtl/dcache_ctrl_if.sv | 28 ++
 rtl/dcache_array.sv | 53 +++++
 rtl/dcache_ctrl.sv | 102 ++++++++++
 tb/tb_dcache_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM encoding, default address-field widths and byte-enable merge for the data cache.
package dcache_pkg;
  localparam int DC_LINE_ADDR_LEN = 3;
  localparam int DC_SET_ADDR_LEN  = 4;
  localparam int DC_TAG_ADDR_LEN  = 32 - 2 - DC_LINE_ADDR_LEN - DC_SET_ADDR_LEN;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WBACK = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    logic [31:0] m;
    m = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    return m;
  endfunction
endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: requester (MEM stage) and main-memory bus of the data cache.
//   slave  : cache view (takes requests and memory responses, drives load data, stall, beats, counters)
//   master : environment view (core + memory side)
interface dcache_ctrl_if;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_gnt;
  logic [31:0] access_cnt;
  logic [31:0] miss_cnt;
  modport slave (
    input  rd_req, wr_req, addr, wr_data, wr_be, mem_rdata, mem_gnt,
    output rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, access_cnt, miss_cnt
  );
  modport master (
    output rd_req, wr_req, addr, wr_data, wr_be, mem_rdata, mem_gnt,
    input  rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, access_cnt, miss_cnt
  );
endinterface

// File: rtl/dcache_array.sv
// dcache_array: per-set valid/dirty/tag/data storage; synchronous writes, combinational read of the addressed set.
//   i_set                 : set being looked up and written
//   i_tag, i_tag_we       : install tag and mark the set valid
//   i_data_we/off/wdata   : write one word of the set's line
//   i_dirty_set/clr       : dirty bit control
//   o_valid/o_dirty/o_tag : state of i_set; o_line : whole line of i_set
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DC_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DC_SET_ADDR_LEN
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [SET_ADDR_LEN-1:0]                i_set,
  input  logic [32-2-LINE_ADDR_LEN-SET_ADDR_LEN-1:0] i_tag,
  input  logic                                   i_tag_we,
  input  logic                                   i_data_we,
  input  logic [LINE_ADDR_LEN-1:0]               i_data_off,
  input  logic [31:0]                            i_data_wdata,
  input  logic                                   i_dirty_set,
  input  logic                                   i_dirty_clr,
  output logic                                   o_valid,
  output logic                                   o_dirty,
  output logic [32-2-LINE_ADDR_LEN-SET_ADDR_LEN-1:0] o_tag,
  output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]    o_line
);
  localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int WORDS = 1 << LINE_ADDR_LEN;
  localparam int SETS  = 1 << SET_ADDR_LEN;
  logic [SETS-1:0]         r_valid;
  logic [SETS-1:0]         r_dirty;
  logic [TAG_ADDR_LEN-1:0] r_tag  [SETS];
  logic [31:0]             r_data [SETS][WORDS];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_tag_we) r_valid[i_set] <= 1'b1;
      if (i_dirty_set) r_dirty[i_set] <= 1'b1;
      else if (i_dirty_clr) r_dirty[i_set] <= 1'b0;
    end
  always_ff @(posedge clk) begin
    if (i_tag_we) r_tag[i_set] <= i_tag;
    if (i_data_we) r_data[i_set][i_data_off] <= i_data_wdata;
  end
  assign o_valid = r_valid[i_set];
  assign o_dirty = r_dirty[i_set];
  assign o_tag   = r_tag[i_set];
  always_comb
    for (int k = 0; k < WORDS; k++) o_line[k] = r_data[i_set][k];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache with miss stall and hit-rate counters.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : requester port (rd_req/wr_req/addr/wr_data/wr_be -> rd_data/miss),
//              memory beat port (mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_gnt),
//              access_cnt/miss_cnt counters
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DC_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DC_SET_ADDR_LEN
) (
  input logic          clk,
  input logic          rst,
  dcache_ctrl_if.slave bus
);
  localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int WORDS = 1 << LINE_ADDR_LEN;
  logic [1:0]               r_state;
  logic [LINE_ADDR_LEN-1:0] r_beat;
  logic [31:0]              r_rd_data;
  logic [31:0]              r_access_cnt;
  logic [31:0]              r_miss_cnt;
  logic [LINE_ADDR_LEN-1:0] w_off;
  logic [SET_ADDR_LEN-1:0]  w_set;
  logic [TAG_ADDR_LEN-1:0]  w_tag;
  logic [TAG_ADDR_LEN-1:0]  w_line_tag;
  logic [WORDS-1:0][31:0]   w_line;
  logic w_valid, w_dirty, w_hit, w_req, w_idle, w_wb, w_fill, w_last, w_gnt, w_serve, w_alloc;
  logic w_data_we, w_tag_we, w_dirty_set, w_dirty_clr;
  logic [LINE_ADDR_LEN-1:0] w_data_off;
  logic [31:0]              w_data_wdata;
  assign w_off = bus.addr[LINE_ADDR_LEN+1:2];
  assign w_set = bus.addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign w_tag = bus.addr[31:LINE_ADDR_LEN+SET_ADDR_LEN+2];
  assign w_req   = bus.rd_req | bus.wr_req;
  assign w_hit   = w_valid & (w_line_tag == w_tag);
  assign w_idle  = r_state == IDLE;
  assign w_wb    = r_state == WBACK;
  assign w_fill  = r_state == FILL;
  assign w_last  = r_beat == '1;
  assign w_gnt   = bus.mem_gnt & (w_wb | w_fill);
  assign w_serve = w_idle & w_req & w_hit;
  assign w_alloc = w_idle & w_req & ~w_hit;
  // Memory beats are decoded from state so they vanish the instant reset is asserted.
  assign bus.miss      = (w_req & ~w_hit) | ~w_idle;
  assign bus.mem_req   = w_wb | w_fill;
  assign bus.mem_we    = w_wb;
  assign bus.mem_addr  = w_wb ? {w_line_tag, w_set, r_beat, 2'b00} : w_fill ? {w_tag, w_set, r_beat, 2'b00} : '0;
  assign bus.mem_wdata = w_wb ? w_line[r_beat] : '0;
  assign bus.rd_data    = r_rd_data;
  assign bus.access_cnt = r_access_cnt;
  assign bus.miss_cnt   = r_miss_cnt;
  // Wr_req dominates: a cycle with both requests merges the store and leaves rd_data alone.
  assign w_data_we    = (w_fill & w_gnt) | (w_serve & bus.wr_req);
  assign w_data_off   = w_fill ? r_beat : w_off;
  assign w_data_wdata = w_fill ? bus.mem_rdata : be_merge(w_line[w_off], bus.wr_data, bus.wr_be);
  assign w_tag_we     = w_fill & w_gnt & w_last;
  assign w_dirty_set  = w_serve & bus.wr_req;
  assign w_dirty_clr  = w_wb & w_gnt & w_last;
  dcache_array #(
    .LINE_ADDR_LEN(LINE_ADDR_LEN),
    .SET_ADDR_LEN (SET_ADDR_LEN)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_set       (w_set),
    .i_tag       (w_tag),
    .i_tag_we    (w_tag_we),
    .i_data_we   (w_data_we),
    .i_data_off  (w_data_off),
    .i_data_wdata(w_data_wdata),
    .i_dirty_set (w_dirty_set),
    .i_dirty_clr (w_dirty_clr),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_line_tag),
    .o_line      (w_line)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_rd_data    <= '0;
      r_access_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_serve) begin
        r_access_cnt <= r_access_cnt + 32'd1;
        if (!bus.wr_req) r_rd_data <= w_line[w_off];
      end
      if (w_alloc) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
        r_beat     <= '0;
        r_state    <= (w_valid & w_dirty) ? WBACK : FILL;
      end
      // The beat counter wraps to zero on the last beat, ready for the next burst.
      if (w_gnt) begin
        r_beat <= r_beat + 1'b1;
        if (w_last) r_state <= w_wb ? FILL : IDLE;
      end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized scoreboard bench; the reference treats the cache as transparent flat memory
// plus a per-set residency table that predicts hits, misses and the exact burst sequence.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  dcache_ctrl_if bus ();
  dcache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { bit we; logic [31:0] a; logic [31:0] d; } beat_t;
  typedef struct { bit ld; logic [31:0] d; logic [31:0] acc; logic [31:0] mis; } serve_t;
  beat_t  exp_beat [$];
  serve_t exp_srv  [$];
  logic [31:0] bmem [int unsigned];
  logic [31:0] fmem [int unsigned];
  bit          mv [16];
  bit          md [16];
  logic [22:0] mt [16];
  logic [31:0] e_acc, e_mis;
  int n_chk = 0, n_err = 0, n_beats = 0;
  bit gnt_always = 1'b0;
  bit pend = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s", name);
  endtask
  function automatic logic [31:0] rd_mem(input logic [31:0] w, input bit flat);
    if (flat) return fmem.exists(w) ? fmem[w] : 32'h1000_0000 + w;
    return bmem.exists(w) ? bmem[w] : 32'h1000_0000 + w;
  endfunction
  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      mv[s] = 1'b0;
      md[s] = 1'b0;
    end
    e_acc = '0;
    e_mis = '0;
  endtask
  task automatic do_req(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int waits);
    logic [3:0]  s;
    logic [22:0] t;
    logic [31:0] wa, old, nw;
    beat_t  bt;
    serve_t sv;
    s = a[8:5];
    t = a[31:9];
    wa = a >> 2;
    if (!(mv[s] && mt[s] == t)) begin
      e_mis++;
      if (mv[s] && md[s])
        for (int b = 0; b < 8; b++) begin
          bt.we = 1'b1;
          bt.a  = (32'(mt[s]) << 9) | (32'(s) << 5) | (b << 2);
          bt.d  = rd_mem(bt.a >> 2, 1'b1);
          exp_beat.push_back(bt);
        end
      for (int b = 0; b < 8; b++) begin
        bt.we = 1'b0;
        bt.a  = (32'(t) << 9) | (32'(s) << 5) | (b << 2);
        bt.d  = '0;
        exp_beat.push_back(bt);
      end
      mv[s] = 1'b1;
      md[s] = 1'b0;
      mt[s] = t;
    end
    e_acc++;
    sv.ld = !w;
    sv.d  = rd_mem(wa, 1'b1);
    if (w) begin
      old = rd_mem(wa, 1'b1);
      nw = old;
      for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = d[8*b +: 8];
      fmem[wa] = nw;
      md[s] = 1'b1;
    end
    sv.acc = e_acc;
    sv.mis = e_mis;
    exp_srv.push_back(sv);
    bus.rd_req = r;
    bus.wr_req = w;
    bus.addr = a;
    bus.wr_data = d;
    bus.wr_be = be;
    waits = 0;
    @(negedge clk);
    while (bus.miss && waits < 1000) begin
      waits++;
      @(negedge clk);
    end
    if (bus.miss) fail("serve_timeout");
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
  endtask
  // Memory responder and beat checker.
  initial begin
    bus.mem_gnt = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && bus.mem_req) begin
        bus.mem_gnt = gnt_always || ($urandom_range(0, 2) != 0);
        bus.mem_rdata = rd_mem(bus.mem_addr >> 2, 1'b0);
        if (bus.mem_gnt) begin
          n_beats++;
          if (exp_beat.size() == 0) fail("beat_unexpected");
          else begin
            beat_t e;
            e = exp_beat.pop_front();
            chk("beat_we", 32'(bus.mem_we), 32'(e.we));
            chk("beat_addr", bus.mem_addr, e.a);
            if (e.we) chk("beat_wdata", bus.mem_wdata, e.d);
          end
          if (bus.mem_we) bmem[bus.mem_addr >> 2] = bus.mem_wdata;
        end
      end else begin
        bus.mem_gnt = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end
    end
  end
  // Serve monitor: a request seen unstalled at a falling edge is served at the next rising edge.
  initial forever begin
    @(negedge clk);
    if (pend && rst) begin
      if (exp_srv.size() == 0) fail("serve_unexpected");
      else begin
        serve_t s;
        s = exp_srv.pop_front();
        if (s.ld) chk("rd_data", bus.rd_data, s.d);
        chk("access_cnt", bus.access_cnt, s.acc);
        chk("miss_cnt", bus.miss_cnt, s.mis);
      end
    end
    pend = rst && (bus.rd_req || bus.wr_req) && !bus.miss;
  end
  initial begin
    #3_000_000;
    fail("watchdog");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "timeout");
  end
  initial begin
    int waits, nb, gw;
    logic [31:0] a;
    bit w;
    model_reset();
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    bus.addr = '0;
    bus.wr_data = '0;
    bus.wr_be = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_miss", 32'(bus.miss), 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_access_cnt", bus.access_cnt, 0);
    chk("rst_miss_cnt", bus.miss_cnt, 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset in the middle of a fill, at beat 3.
    gnt_always = 1'b1;
    nb = n_beats;
    bus.rd_req = 1'b1;
    bus.addr = 32'h100;
    for (int b = 0; b < 8; b++) exp_beat.push_back('{1'b0, 32'h100 + 4 * b, 32'h0});
    gw = 0;
    do begin
      @(negedge clk);
      #1;
      gw++;
    end while (n_beats != nb + 3 && gw < 100);
    chk("fill_progress", n_beats, nb + 3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_req", 32'(bus.mem_req), 0);
    chk("arst_miss", 32'(bus.miss), 1);
    chk("arst_miss_cnt", bus.miss_cnt, 0);
    bus.rd_req = 1'b0;
    exp_beat.delete();
    exp_srv.delete();
    model_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    // Cold load after reset: full fill, no write-back.
    nb = n_beats;
    do_req(1'b0, 1'b1, 32'h100, 0, 0, waits);
    chk("cold_beats", n_beats, nb + 8);
    chk("cold_rd_data", bus.rd_data, 32'h1000_0040);
    chk("cold_miss_cnt", bus.miss_cnt, 1);
    chk("cold_access_cnt", bus.access_cnt, 1);
    nb = n_beats;
    do_req(1'b0, 1'b1, 32'h104, 0, 0, waits);
    chk("hit_no_stall", waits, 0);
    chk("hit_no_beats", n_beats, nb);
    chk("hit_rd_data", bus.rd_data, 32'h1000_0041);
    gnt_always = 1'b0;
    do_req(1'b1, 1'b0, 32'h100, 32'hAABB_CCDD, 4'b0011, waits);
    chk("store_hit_no_stall", waits, 0);
    nb = n_beats;
    do_req(1'b0, 1'b1, 32'h300, 0, 0, waits);
    chk("evict_beats", n_beats, nb + 16);
    chk("evict_miss_cnt", bus.miss_cnt, 2);
    do_req(1'b1, 1'b1, 32'h500, 32'h1234_5678, 4'b1100, waits);
    do_req(1'b0, 1'b1, 32'h500, 0, 0, waits);
    chk("store_miss_merge", bus.rd_data, 32'h1234_0140);
    do_req(1'b0, 1'b1, 32'h100, 0, 0, waits);
    chk("writeback_roundtrip", bus.rd_data, 32'h1000_CCDD);
    for (int i = 0; i < 250; i++) begin
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(6, 9) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      w = $urandom_range(0, 1);
      do_req(w, w ? 1'($urandom_range(0, 1)) : 1'b1, a, $urandom, 4'($urandom), waits);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("beats_left", exp_beat.size(), 0);
    chk("serves_left", exp_srv.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
